// File: rtl/parity_unit_if.sv
// Handshake/bus bundle for the UART parity engine: TX word strobe, RX bit stream,
// and the registered status outputs.
interface parity_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_Valid;
  logic                  PAR_EN;
  logic [1:0]            PAR_TYP;
  logic                  S_START;
  logic                  S_VALID;
  logic                  S_BIT;
  logic                  ERR_CLR;
  logic                  par_bit;
  logic                  par_valid;
  logic                  chk_busy;
  logic                  chk_done;
  logic                  par_err;
  logic [ERR_CNT_W-1:0]  err_cnt;

  modport master (
    output P_DATA, DATA_Valid, PAR_EN, PAR_TYP, S_START, S_VALID, S_BIT, ERR_CLR,
    input  par_bit, par_valid, chk_busy, chk_done, par_err, err_cnt
  );

  modport slave (
    input  P_DATA, DATA_Valid, PAR_EN, PAR_TYP, S_START, S_VALID, S_BIT, ERR_CLR,
    output par_bit, par_valid, chk_busy, chk_done, par_err, err_cnt
  );
endinterface

// File: rtl/parity_unit.sv
// UART parity engine: TX parity generation for a parallel word and an RX frame
// checker (IDLE/DATA/PARITY) with a saturating parity-error counter.
module parity_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic          CLK,
  input  logic          RST,
  parity_unit_if.slave  bus
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 acc;
  logic [1:0]           typ_l;
  logic                 par_bit_q, par_valid_q, busy_q, done_q, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 rx_eval, rx_mis;

  function automatic logic par_f(input logic [1:0] typ, input logic x);
    case (typ)
      2'b00:   return x;
      2'b01:   return ~x;
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // A start strobe always wins over a coincident sampled bit, including the parity bit.
  always_comb begin
    rx_eval = (state == PARITY) && bus.S_VALID && !bus.S_START;
    rx_mis  = rx_eval && (bus.S_BIT != par_f(typ_l, acc));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= 1'b0;
      typ_l       <= 2'b00;
      par_bit_q   <= 1'b0;
      par_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      par_valid_q <= 1'b0;
      if (bus.DATA_Valid && bus.PAR_EN) begin
        par_bit_q   <= par_f(bus.PAR_TYP, ^bus.P_DATA);
        par_valid_q <= 1'b1;
      end

      done_q <= rx_eval;
      err_q  <= rx_mis;
      if (bus.ERR_CLR)
        err_cnt_q <= '0;
      else if (rx_mis && err_cnt_q != ERR_MAX)
        err_cnt_q <= err_cnt_q + 1'b1;

      if (bus.S_START) begin
        if (bus.PAR_EN) begin
          state  <= DATA;
          busy_q <= 1'b1;
          acc    <= 1'b0;
          cnt    <= '0;
          typ_l  <= bus.PAR_TYP;
        end else if (state != IDLE) begin
          // parity disabled: a new frame aborts the current one but is not checked
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      end else begin
        case (state)
          DATA: if (bus.S_VALID) begin
            acc <= acc ^ bus.S_BIT;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DATA_WIDTH - 1)) state <= PARITY;
          end
          PARITY: if (bus.S_VALID) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.par_bit   = par_bit_q;
  assign bus.par_valid = par_valid_q;
  assign bus.chk_busy  = busy_q;
  assign bus.chk_done  = done_q;
  assign bus.par_err   = err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule
